// File: rtl/apb_mem_slave_pkg.sv
// Shared types and constants for the APB memory slave: FSM state encoding
// and the upper bound on configurable wait states.
`timescale 1ns/1ps
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_mem_state_t;

    localparam int MAX_WAIT_STATES = 15;

    function automatic int byte_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB4 bus bundle for the memory slave. PPROT exists only when
// APB_MEM_PROT_EN is defined.
`timescale 1ns/1ps
interface apb_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
`ifdef APB_MEM_PROT_EN
    logic [2:0]                PPROT;
`endif
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
`ifdef APB_MEM_PROT_EN
        output PPROT,
`endif
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
`ifdef APB_MEM_PROT_EN
        input  PPROT,
`endif
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_mem_slave_array.sv
// Byte-lane-writable RAM: synchronous write, combinational read so the
// slave can register read data on the APB setup edge.
`timescale 1ns/1ps
module apb_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [STRB_W-1:0]     strb,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (strb[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB4 scratch-RAM slave with byte strobes, PSLVERR on bad
// addresses and configurable wait states. APB_MEM_PROT_EN adds PPROT checking.
`timescale 1ns/1ps
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
`ifdef APB_MEM_PROT_EN
    parameter int PROT_BASE   = MEM_DEPTH / 2,
`endif
    parameter int WAIT_STATES = 0
) (
    input logic            PCLK,
    input logic            PRESETn,
    apb_mem_slave_if.slave bus
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = byte_shift(DATA_WIDTH);
    localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int WIDX_W     = ADDR_WIDTH - BYTE_SHIFT;
    localparam int CNT_W      = $clog2(MAX_WAIT_STATES + 1);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'((64'd1 << BYTE_SHIFT) - 64'd1);
    localparam logic [CNT_W-1:0]      WAIT_INIT = CNT_W'(WAIT_STATES);

    apb_mem_state_t        state;
    logic [CNT_W-1:0]      cnt;
    logic                  wr_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     strb_q;

    logic [WIDX_W-1:0]     word_idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  prot_err;
    logic                  decode_err;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  setup;
    logic                  access_cyc;
    logic                  we;

    assign word_idx     = bus.PADDR[ADDR_WIDTH-1:BYTE_SHIFT];
    assign misaligned   = |(bus.PADDR & LANE_MASK);
    assign out_of_range = (64'(word_idx) >= 64'(MEM_DEPTH));
`ifdef APB_MEM_PROT_EN
    // Unprivileged masters may not touch the upper, protected window.
    assign prot_err     = !bus.PPROT[0] && (64'(word_idx) >= 64'(PROT_BASE));
`else
    assign prot_err     = 1'b0;
`endif
    assign decode_err   = misaligned | out_of_range | prot_err;

    assign setup      = bus.PSEL && !bus.PENABLE;
    assign access_cyc = bus.PSEL && bus.PENABLE;
    assign we         = (state == ACCESS) && access_cyc && (cnt == '0) && wr_q && !err_q;

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk   (PCLK),
        .we    (we),
        .strb  (strb_q),
        .widx  (idx_q),
        .wdata (wdata_q),
        .ridx  (word_idx[IDX_W-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // PSEL+PENABLE without a preceding setup is ignored.
                    if (setup) begin
                        wr_q  <= bus.PWRITE;
                        err_q <= decode_err;
                        cnt   <= WAIT_INIT;
                        state <= ACCESS;
                        if (!bus.PWRITE) begin
                            prdata_q <= decode_err ? '0 : mem_rdata;
                        end
                    end
                end
                ACCESS: begin
                    if (access_cyc && (cnt != '0)) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write payload is only consumed behind the registered control above.
    always_ff @(posedge PCLK) begin
        if ((state == IDLE) && setup) begin
            idx_q   <= word_idx[IDX_W-1:0];
            wdata_q <= bus.PWDATA;
            strb_q  <= bus.PSTRB;
        end
    end

    assign bus.PRDATA  = prdata_q;
    assign bus.PREADY  = (state == ACCESS) && (cnt == '0);
    assign bus.PSLVERR = bus.PREADY && err_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (0, 2 and 3 wait states) driven
// through one APB master task and checked against an associative-array memory model.
`timescale 1ns/1ps
module tb_apb_mem_slave;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    int          dsel;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int ws_of [3]  = '{0, 2, 3};
    logic [31:0] model [int];

    always @(posedge clk) cyc++;

    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();
    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();

    assign if0.PSEL = psel && (dsel == 0);
    assign if1.PSEL = psel && (dsel == 1);
    assign if2.PSEL = psel && (dsel == 2);
    assign if0.PENABLE = penable; assign if1.PENABLE = penable; assign if2.PENABLE = penable;
    assign if0.PWRITE  = pwrite;  assign if1.PWRITE  = pwrite;  assign if2.PWRITE  = pwrite;
    assign if0.PADDR   = paddr;   assign if1.PADDR   = paddr;   assign if2.PADDR   = paddr;
    assign if0.PWDATA  = pwdata;  assign if1.PWDATA  = pwdata;  assign if2.PWDATA  = pwdata;
    assign if0.PSTRB   = pstrb;   assign if1.PSTRB   = pstrb;   assign if2.PSTRB   = pstrb;
`ifdef APB_MEM_PROT_EN
    assign if0.PPROT   = pprot;   assign if1.PPROT   = pprot;   assign if2.PPROT   = pprot;
`endif

    assign prdata  = (dsel == 0) ? if0.PRDATA  : (dsel == 1) ? if1.PRDATA  : if2.PRDATA;
    assign pready  = (dsel == 0) ? if0.PREADY  : (dsel == 1) ? if1.PREADY  : if2.PREADY;
    assign pslverr = (dsel == 0) ? if0.PSLVERR : (dsel == 1) ? if1.PSLVERR : if2.PSLVERR;

    apb_mem_slave #(.WAIT_STATES(0)) dut0 (.PCLK(clk), .PRESETn(rst_n), .bus(if0.slave));
    apb_mem_slave #(.WAIT_STATES(2)) dut1 (.PCLK(clk), .PRESETn(rst_n), .bus(if1.slave));
    apb_mem_slave #(.WAIT_STATES(3)) dut2 (.PCLK(clk), .PRESETn(rst_n), .bus(if2.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] addr);
        logic e;
        e = ((addr % 4) != 0) || ((addr / 4) >= 1024);
`ifdef APB_MEM_PROT_EN
        if (!pprot[0] && ((addr / 4) >= 512)) e = 1'b1;
`endif
        return e;
    endfunction

    // Caller must be positioned 1ns after a rising edge.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rd, output logic err, output int waits);
        dsel = d; psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (pready !== 1'b1 && waits <= 40) begin
            @(posedge clk); #1;
            waits++;
        end
        rd = prdata; err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string tag, output logic [31:0] rd);
        logic        exp_err, err;
        logic [31:0] exp_rd, word;
        int          key, waits;
        exp_err = model_err(addr);
        key     = d * 65536 + int'(addr >> 2);
        exp_rd  = (exp_err || wr) ? 32'h0 : model[key];
        xfer(d, wr, addr, data, strb, rd, err, waits);
        check({tag, ".err"}, 64'(err), 64'(exp_err));
        check({tag, ".wait"}, 64'(waits), 64'(ws_of[d]));
        if (!wr) begin
            check({tag, ".rdata"}, 64'(rd), 64'(exp_rd));
        end else if (!exp_err) begin
            word = model.exists(key) ? model[key] : 32'h0;
            for (int i = 0; i < 4; i++) if (strb[i]) word[8*i +: 8] = data[8*i +: 8];
            model[key] = word;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        int          c0, r, d;

        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
        pprot = 3'b001; dsel = 0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            dsel = i; #1;
            check("reset.prdata", 64'(prdata), 64'h0);
            check("reset.pready", 64'(pready), 64'h0);
            check("reset.pslverr", 64'(pslverr), 64'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 32; w++)
                do_xfer(i, 1'b1, 32'(w * 4), $urandom, 4'hF, "init", rd);

        // Zero-wait write then read
        do_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "ws0.wr", rd);
        do_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, "ws0.rd", rd);
        check("ws0.value", 64'(rd), 64'hDEADBEEF);

        // Byte strobes
        do_xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, "strb.full", rd);
        do_xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "strb.part", rd);
        do_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, "strb.rd", rd);
        check("strb.value", 64'(rd), 64'h11BB33DD);
        do_xfer(0, 1'b1, 32'h20, 32'h55555555, 4'h0, "strb.none", rd);
        do_xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, "strb.none_rd", rd);
        check("strb.none_value", 64'(rd), 64'h11BB33DD);

        // Two wait states, back-to-back without idle cycle
        do_xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, "ws2.rd", rd);
        c0 = cyc;
        do_xfer(1, 1'b1, 32'h40, 32'hC0FFEE11, 4'hF, "ws2.b2b_wr", rd);
        do_xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, "ws2.b2b_rd", rd);
        check("ws2.b2b_cycles", 64'(cyc - c0), 64'd8);
        check("ws2.b2b_value", 64'(rd), 64'hC0FFEE11);

        // Error responses
        do_xfer(0, 1'b0, 32'h1002, 32'h0, 4'hF, "err.misaligned", rd);
        do_xfer(0, 1'b1, 32'h0, 32'h01020304, 4'hF, "err.w0", rd);
        do_xfer(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, "err.oor_wr", rd);
        do_xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, "err.w0_rd", rd);
        check("err.w0_value", 64'(rd), 64'h01020304);

        // Abort mid-ACCESS with three wait states
        do_xfer(2, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF, "abort.pre", rd);
        dsel = 2; psel = 1; penable = 0; pwrite = 1; paddr = 32'h14; pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1;
        check("abort.busy", 64'(pready), 64'h0);
        @(posedge clk); #1;
        psel = 0; penable = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort.idle", 64'(pready), 64'h0);
        end
        do_xfer(2, 1'b0, 32'h14, 32'h0, 4'hF, "abort.rd", rd);
        check("abort.value", 64'(rd), 64'hCAFEF00D);

        // Reset pulse during a write access
        dsel = 2; psel = 1; penable = 0; pwrite = 1; paddr = 32'h14; pwdata = 32'h0BADBEEF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1;
        check("rst.hold_prdata", 64'(prdata), 64'hCAFEF00D);
        #2 rst_n = 1'b0;
        #1;
        check("rst.prdata", 64'(prdata), 64'h0);
        check("rst.pready", 64'(pready), 64'h0);
        check("rst.pslverr", 64'(pslverr), 64'h0);
        psel = 0; penable = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_xfer(2, 1'b0, 32'h14, 32'h0, 4'hF, "rst.rd", rd);
        check("rst.value", 64'(rd), 64'hCAFEF00D);

        // PSEL+PENABLE seen in IDLE is ignored
        dsel = 0; psel = 1; penable = 1; pwrite = 0; paddr = 32'h10;
        @(posedge clk); #1;
        check("proto.ignored", 64'(pready), 64'h0);
        psel = 0; penable = 0;
        @(posedge clk); #1;

`ifdef APB_MEM_PROT_EN
        pprot = 3'b001;
        do_xfer(0, 1'b1, 32'(600 * 4), 32'hA5A5A5A5, 4'hF, "prot.priv_wr", rd);
        pprot = 3'b000;
        do_xfer(0, 1'b1, 32'(600 * 4), 32'h5A5A5A5A, 4'hF, "prot.user_wr", rd);
        do_xfer(0, 1'b0, 32'(600 * 4), 32'h0, 4'hF, "prot.user_rd", rd);
        pprot = 3'b001;
        do_xfer(0, 1'b0, 32'(600 * 4), 32'h0, 4'hF, "prot.priv_rd", rd);
        check("prot.value", 64'(rd), 64'hA5A5A5A5);
`endif

        // Randomised traffic against the model
        for (int n = 0; n < 60; n++) begin
            d = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            if (r == 0)      addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            else if (r == 1) addr = 32'($urandom_range(1024, 4095) * 4);
            else             addr = 32'($urandom_range(0, 31) * 4);
`ifdef APB_MEM_PROT_EN
            pprot = 3'($urandom_range(0, 7));
`endif
            do_xfer(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), "rand", rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- Parametrised APB4 memory slave, successor to the fixed-width APB memory slave in the apb_dpmem subsystem.
- Generalises address width, data width, memory depth and wait-state count.
- Adds byte strobes (PSTRB), PSLVERR on bad addresses, and zero-wait transfers where WAIT_STATES=0.
- Sits behind the APB interconnect as the subsystem's on-chip scratch RAM.

Parameters:
- ADDR_WIDTH, 32: PADDR width in bits (byte address).
- DATA_WIDTH, 32: PWDATA/PRDATA width. Must be 8, 16, 32 or 64.
- MEM_DEPTH, 1024: number of DATA_WIDTH-bit words.
- WAIT_STATES, 0: PREADY-low cycles inserted in the access phase. Range 0..15.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte enables.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error, valid only while PREADY=1.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; PRDATA=0, PREADY=0, PSLVERR=0, wait counter=0.
  - Memory contents are not reset.
- Address decode:
  - BYTE_SHIFT = log2(DATA_WIDTH/8); word index = PADDR >> BYTE_SHIFT.
  - err = (PADDR[BYTE_SHIFT-1:0] != 0) OR (word index >= MEM_DEPTH).
- FSM states: IDLE, ACCESS.
- IDLE:
  - On a setup cycle (PSEL=1, PENABLE=0), at the clock edge the block latches PADDR, PWRITE, PWDATA, PSTRB and err.
  - Same edge: PRDATA <= err ? 0 : MEM[index] for reads; PRDATA holds its value for writes.
  - Same edge: cnt <= WAIT_STATES; next state ACCESS.
  - PSEL=1 with PENABLE=1 while in IDLE is a protocol violation: ignored, stay in IDLE.
- ACCESS outputs:
  - PREADY = (cnt==0), driven from registered state only (no combinational path from inputs).
  - PSLVERR = latched err while PREADY=1, else 0.
- ACCESS transitions:
  - PSEL=1, PENABLE=1, cnt!=0: cnt decrements.
  - PSEL=1, PENABLE=1, cnt==0: completion edge. If latched PWRITE and !err, write each byte lane i with PSTRB[i]=1 from latched PWDATA. Next state IDLE.
  - PSEL=0 or PENABLE=0 (aborted transfer): return to IDLE, no write, PREADY=0.
- Latency:
  - Transfer = setup + (WAIT_STATES+1) access cycles.
  - WAIT_STATES=0 gives standard 2-cycle APB transfers.
  - Back-to-back transfers have no idle gap: the cycle after completion can be the next setup.
- Read-after-write to the same word in the next transfer returns the new data, since the write completes before the next setup edge.
- Reads ignore PSTRB.
- An erroring write leaves memory unchanged; an erroring read returns PRDATA=0.
- PSTRB=0 on a valid write: no memory change, PSLVERR=0.
- Reset asserted mid-transfer: pending write dropped, outputs go to reset values immediately.

Optional Feature:
- Macro APB_MEM_PROT_EN.
- Defined:
  - Adds input PPROT[2:0] and parameter PROT_BASE (default MEM_DEPTH/2, in words).
  - Unprivileged access (latched PPROT[0]==0) to word index >= PROT_BASE sets err: PSLVERR, no write, PRDATA=0.
- Undefined: no PPROT port, no protection check.

Decomposition:
- apb_pkg gains apb_mem_state_t (IDLE, ACCESS) and the constant MAX_WAIT_STATES=15.
- Widths stay as module parameters, not package typedefs.
- One sub-module, apb_mem_array:
  - Byte-lane-writable synchronous RAM.
  - Ports: clk, we, strb, widx, wdata, ridx, rdata.
  - The FSM wraps it.

Test Plan:
- Reset, WAIT_STATES=0: PRESETn low -> PRDATA=0, PREADY=0, PSLVERR=0. Write 0xDEADBEEF to 0x10, read 0x10 -> PRDATA=0xDEADBEEF, PREADY high in the 2nd transfer cycle.
- Strobes: write 0x11223344 to 0x20, then 0xAABBCCDD with PSTRB=4'b0101 -> read returns 0x11BB33DD.
- Wait states, WAIT_STATES=2: read -> PREADY low for 2 access cycles, high on the 3rd; back-to-back write+read to 0x40 -> correct data with no idle gap.
- Errors: read 0x1002 (misaligned) -> PSLVERR=1, PRDATA=0. Write 0x1000 (index 1024) -> PSLVERR=1; word 0 unchanged.
- Abort/reset: PSEL dropped mid-ACCESS with WAIT_STATES=3 -> no write, FSM in IDLE. PRESETn pulsed during ACCESS -> outputs reset, memory word unchanged.
- APB_MEM_PROT_EN: PPROT=3'b000 write to word 600 -> PSLVERR=1, no change. PPROT=3'b001 -> write succeeds.
